// File: rtl/aes_pkg.sv
// Shared AES definitions: state matrix type, round count and datapath modes.
package aes_pkg;

  // 4x4 byte state, indexed [row][col].
  typedef logic [3:0][3:0][7:0] state_t;

  // Round count for AES-128.
  localparam int NR_AES128 = 10;

  // Round datapath operating modes.
  localparam logic [1:0] DP_FIRST = 2'd0;  // AddRoundKey only
  localparam logic [1:0] DP_MID   = 2'd1;  // SubBytes, ShiftRows, MixColumns, AddRoundKey
  localparam logic [1:0] DP_FINAL = 2'd2;  // SubBytes, ShiftRows, AddRoundKey

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption sequencer. Drives one shared round datapath and a
// 1-cycle-latency round-key memory through a complete block encryption.
// Round keys are prefetched one round ahead so that in RUN the key on rk_data
// always belongs to the round being computed and the key memory never stalls.
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int NR = NR_AES128,
  parameter int CW = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0][3:0][7:0]    in_state,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [3:0][3:0][7:0]    out_state,
  input  logic                    abort,
  output logic                    busy,
  output logic                    rk_rd_en,
  output logic [CW-1:0]           rk_addr,
  input  logic [3:0][3:0][7:0]    rk_data,
  output logic                    dp_en,
  output logic [1:0]              dp_mode,
  output logic [3:0][3:0][7:0]    dp_state,
  output logic [3:0][3:0][7:0]    dp_key,
  input  logic [3:0][3:0][7:0]    dp_result
);

  // Final round index in counter width.
  localparam logic [CW-1:0] LP_NR = CW'(NR);

  // Registered state
  seq_state_e    r_fsm;
  logic [CW-1:0] r_rd_cnt;
  logic [CW-1:0] r_rnd_cnt;
  logic [CW-1:0] r_rk_addr;
  logic          r_rk_rd_en;
  state_t        r_st;

  // Next-state values
  seq_state_e    w_fsm_nxt;
  logic [CW-1:0] w_rd_cnt_nxt;
  logic [CW-1:0] w_rnd_cnt_nxt;
  logic [CW-1:0] w_rk_addr_nxt;
  logic          w_rk_rd_en_nxt;
  state_t        w_st_nxt;

  // Combinational outputs
  logic          w_in_ready;
  logic          w_out_valid;
  logic          w_dp_en;
  logic [1:0]    w_dp_mode;

  // State register and counters; reset returns everything to an idle, empty block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fsm      <= ST_IDLE;
      r_rd_cnt   <= '0;
      r_rnd_cnt  <= '0;
      r_rk_addr  <= '0;
      r_rk_rd_en <= 1'b0;
      r_st       <= '0;
    end else begin
      r_fsm      <= w_fsm_nxt;
      r_rd_cnt   <= w_rd_cnt_nxt;
      r_rnd_cnt  <= w_rnd_cnt_nxt;
      r_rk_addr  <= w_rk_addr_nxt;
      r_rk_rd_en <= w_rk_rd_en_nxt;
      r_st       <= w_st_nxt;
    end
  end

  // Next-state, key-prefetch and handshake decode; abort wins over normal progress.
  always_comb begin
    w_fsm_nxt      = r_fsm;
    w_rd_cnt_nxt   = r_rd_cnt;
    w_rnd_cnt_nxt  = r_rnd_cnt;
    w_rk_addr_nxt  = r_rk_addr;
    w_rk_rd_en_nxt = 1'b0;
    w_st_nxt       = r_st;
    w_in_ready     = 1'b0;
    w_out_valid    = 1'b0;
    w_dp_en        = 1'b0;
    w_dp_mode      = DP_FIRST;

    case (r_fsm)
      ST_IDLE: begin
        // abort is ignored here, so an accept in the same cycle still happens
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_st_nxt       = in_state;
          w_rk_rd_en_nxt = 1'b1;
          w_rk_addr_nxt  = '0;
          w_rd_cnt_nxt   = CW'(1);
          w_rnd_cnt_nxt  = '0;
          w_fsm_nxt      = ST_PRIME;
        end
      end

      ST_PRIME: begin
        // Key 0 is in flight; issue key 1 so it lands one cycle after key 0.
        if (abort) begin
          w_fsm_nxt = ST_IDLE;
        end else begin
          w_rk_rd_en_nxt = 1'b1;
          w_rk_addr_nxt  = r_rd_cnt;
          w_rd_cnt_nxt   = r_rd_cnt + 1'b1;
          w_fsm_nxt      = ST_RUN;
        end
      end

      ST_RUN: begin
        if (r_rnd_cnt == '0) begin
          w_dp_mode = DP_FIRST;
        end else if (r_rnd_cnt == LP_NR) begin
          w_dp_mode = DP_FINAL;
        end else begin
          w_dp_mode = DP_MID;
        end

        if (abort) begin
          // Result is discarded: the state register keeps its value.
          w_fsm_nxt = ST_IDLE;
        end else begin
          w_dp_en       = 1'b1;
          w_st_nxt      = dp_result;
          w_rnd_cnt_nxt = r_rnd_cnt + 1'b1;
          // Prefetch stops after key NR; rd_cnt therefore tops out at NR+1.
          if (r_rd_cnt <= LP_NR) begin
            w_rk_rd_en_nxt = 1'b1;
            w_rk_addr_nxt  = r_rd_cnt;
            w_rd_cnt_nxt   = r_rd_cnt + 1'b1;
          end
          if (r_rnd_cnt == LP_NR) begin
            w_fsm_nxt = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        // Transfer with a simultaneous abort still counts as delivered.
        w_out_valid = 1'b1;
        if (out_ready || abort) begin
          w_fsm_nxt = ST_IDLE;
        end
      end

      default: begin
        w_fsm_nxt = ST_IDLE;
      end
    endcase
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_state = r_st;
  assign busy      = (r_fsm != ST_IDLE);
  assign rk_rd_en  = r_rk_rd_en;
  assign rk_addr   = r_rk_addr;
  assign dp_en     = w_dp_en;
  assign dp_mode   = w_dp_mode;
  assign dp_state  = r_st;
  assign dp_key    = rk_data;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: stub key memory plus an XOR stub datapath or
// a golden AES-128 round model, with a scoreboard of expected ciphertexts.
module tb_aes_round_sequencer;
  import aes_pkg::*;

  localparam int NR = 10;
  localparam int CW = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  state_t               in_state;
  logic                 out_valid;
  logic                 out_ready;
  state_t               out_state;
  logic                 abort;
  logic                 busy;
  logic                 rk_rd_en;
  logic [CW-1:0]        rk_addr;
  state_t               rk_data;
  logic                 dp_en;
  logic [1:0]           dp_mode;
  state_t               dp_state;
  state_t               dp_key;
  state_t               dp_result;

  state_t               keymem [0:15];
  logic                 use_xor;
  state_t               exp_q [$];
  int                   n_pass = 0;
  int                   n_tot  = 0;
  int                   n_fail = 0;

  aes_round_sequencer #(.NR(NR), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .abort     (abort),
    .busy      (busy),
    .rk_rd_en  (rk_rd_en),
    .rk_addr   (rk_addr),
    .rk_data   (rk_data),
    .dp_en     (dp_en),
    .dp_mode   (dp_mode),
    .dp_state  (dp_state),
    .dp_key    (dp_key),
    .dp_result (dp_result)
  );

  always #5 clk = ~clk;

  // ---------------- AES reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    logic [7:0] b;
    // multiplicative inverse as x^254
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    b = r;
    return b ^ rotl(b) ^ rotl(rotl(b)) ^ rotl(rotl(rotl(b))) ^ rotl(rotl(rotl(rotl(b)))) ^ 8'h63;
  endfunction

  function automatic state_t aes_round(input state_t s, input state_t k, input logic [1:0] mode);
    state_t u;
    state_t m;
    logic [7:0] a0, a1, a2, a3;
    if (mode == DP_FIRST) return s ^ k;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        u[r][c] = sbox(s[r][(c + r) % 4]);
    if (mode == DP_MID) begin
      for (int c = 0; c < 4; c++) begin
        a0 = u[0][c]; a1 = u[1][c]; a2 = u[2][c]; a3 = u[3][c];
        m[0][c] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        m[1][c] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        m[2][c] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        m[3][c] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
      u = m;
    end
    return u ^ k;
  endfunction

  function automatic state_t to_state(input logic [127:0] b);
    state_t s;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = b[127 - 8 * (r + 4 * c) -: 8];
    return s;
  endfunction

  function automatic state_t model_encrypt(input state_t pt);
    state_t s;
    logic [1:0] md;
    s = pt;
    for (int r = 0; r <= NR; r++) begin
      md = (r == 0) ? DP_FIRST : ((r == NR) ? DP_FINAL : DP_MID);
      s = aes_round(s, keymem[r], md);
    end
    return s;
  endfunction

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++)
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++)
          keymem[r][j][c] = w[4 * r + c][31 - 8 * j -: 8];
  endtask

  // ---------------- stub key memory and datapath ----------------
  always @(posedge clk) begin
    if (rk_rd_en) rk_data <= keymem[rk_addr];
  end

  always_comb begin
    dp_result = use_xor ? (dp_state ^ dp_key) : aes_round(dp_state, dp_key, dp_mode);
  end

  // ---------------- check helpers ----------------
  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_n(input string tag, input int obs, input int exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_s(input string tag, input state_t obs, input state_t exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk_b({tag, "_in_ready"},  in_ready,  1'b1);
    chk_b({tag, "_out_valid"}, out_valid, 1'b0);
    chk_b({tag, "_busy"},      busy,      1'b0);
    chk_b({tag, "_rk_rd_en"},  rk_rd_en,  1'b0);
    chk_n({tag, "_rk_addr"},   int'(rk_addr), 0);
    chk_b({tag, "_dp_en"},     dp_en,     1'b0);
    chk_n({tag, "_dp_mode"},   int'(dp_mode), 0);
    chk_s({tag, "_state"},     out_state, '0);
  endtask

  // Drives one accept cycle; returns in cycle 1 after the accept edge.
  task automatic accept(input string tag, input state_t pt, input bit push, input state_t exp);
    chk_b({tag, "_acc_ready"}, in_ready, 1'b1);
    in_state = pt;
    in_valid = 1'b1;
    if (push) exp_q.push_back(exp);
    tick();
    in_valid = 1'b0;
  endtask

  // Called in cycle 1; waits for out_valid, checks latency and data, then drains.
  task automatic wait_out(input string tag);
    int lat;
    state_t e;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk_n({tag, "_latency"}, lat, NR + 3);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 'x;
    chk_s({tag, "_data"}, out_state, e);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_b({tag, "_idle_ready"}, in_ready, 1'b1);
    chk_b({tag, "_idle_valid"}, out_valid, 1'b0);
  endtask

  task automatic expect_no_output(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    chk_b(tag, seen, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    state_t pt, ct, e;
    int     md;

    rst       = 1'b0;
    in_valid  = 1'b0;
    in_state  = '0;
    out_ready = 1'b0;
    abort     = 1'b0;
    use_xor   = 1'b1;
    for (int i = 0; i < 16; i++) keymem[i] = {16{8'(i)}};

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    tick();

    // XOR stub: all-zero input folds to XOR of 0..10 = 0x0B in every byte
    accept("xor", '0, 1'b1, {16{8'h0b}});
    wait_out("xor");

    // FIPS-197 vector with golden round model and per-cycle sequencing checks
    use_xor = 1'b0;
    expand_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    pt = to_state(128'h3243f6a8885a308d313198a2e0370734);
    ct = to_state(128'h3925841d02dc09fbdc118597196a0b32);
    tick();
    accept("fips", pt, 1'b1, ct);
    for (int k = 1; k <= 13; k++) begin
      if (k <= 11) begin
        chk_b($sformatf("rk_rd_en_c%0d", k), rk_rd_en, 1'b1);
        chk_n($sformatf("rk_addr_c%0d", k), int'(rk_addr), k - 1);
      end else begin
        chk_b($sformatf("rk_rd_en_c%0d", k), rk_rd_en, 1'b0);
      end
      if (k == 1) chk_b("dp_en_c1", dp_en, 1'b0);
      if (k >= 2 && k <= 12) begin
        md = (k == 2) ? 0 : ((k == 12) ? 2 : 1);
        chk_b($sformatf("dp_en_c%0d", k), dp_en, 1'b1);
        chk_n($sformatf("dp_mode_c%0d", k), int'(dp_mode), md);
      end
      chk_b($sformatf("out_valid_c%0d", k), out_valid, (k == 13));
      if (k < 13) tick();
    end
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 'x;
    chk_s("fips_ct", out_state, e);

    // Backpressure: out_ready low for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_b("stall_valid", out_valid, 1'b1);
      chk_s("stall_data", out_state, e);
      chk_b("stall_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_b("drain_valid", out_valid, 1'b0);

    // Back-to-back accept right after the drain
    pt = to_state(128'h00112233445566778899aabbccddeeff);
    accept("b2b", pt, 1'b1, model_encrypt(pt));
    wait_out("b2b");

    // Abort in cycle 6
    pt = to_state(128'hdeadbeef0123456789abcdeffedcba98);
    accept("abort_blk", pt, 1'b0, '0);
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_b("abort_busy", busy, 1'b0);
    chk_b("abort_in_ready", in_ready, 1'b1);
    chk_b("abort_out_valid", out_valid, 1'b0);
    expect_no_output("abort_no_out", 16);
    accept("post_abort", pt, 1'b1, model_encrypt(pt));
    wait_out("post_abort");

    // Asynchronous reset mid-clock in cycle 8
    pt = to_state(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0);
    accept("rst_blk", pt, 1'b0, '0);
    repeat (7) tick();
    #3;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    #2;
    rst = 1'b1;
    tick();
    expect_no_output("rst_no_out", 16);

    // Accept with abort asserted in IDLE: abort ignored, block proceeds
    abort = 1'b1;
    accept("post_rst", pt, 1'b1, model_encrypt(pt));
    abort = 1'b0;
    chk_b("idle_abort_busy", busy, 1'b1);
    wait_out("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
